ddr_serializer_tx: RTL and testbench

- Transmit side of the dual-edge sampling link in the feedback path.
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first, one bit per clock edge:
  - bit launched at posedge is valid during clk high phase;
  - bit launched at negedge is valid during clk low phase.
- Output is muxed on clk level, so a dual-edge receiver clocked by the same clk recovers two bits per cycle.
- Runs on the external sampling clock (2.56 MHz nominal).

---
 rtl/ddr_serializer_tx.sv | 134 +++++++++++++
 tb/tb_ddr_serializer_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module      : ddr_serializer_tx
// Description : Transmit side of the dual-edge sampling link. A parallel word
//               is accepted over a valid/ready handshake and shifted out
//               MSB-first, two bits per clk cycle: the bit launched at posedge
//               is driven during the clk high phase and the bit launched at
//               negedge during the clk low phase.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH      - word width in bits (even, >= 2); WIDTH/2 bit-pairs per word
//   IDLE_LEVEL - level on ser_out when no data is in flight
// Ports:
//   clk      in   sampling clock, both edges used
//   rstb     in   asynchronous active-low reset
//   in_data  in   parallel word to send
//   in_valid in   in_data valid
//   in_ready out  word can be accepted at the next posedge
//   ser_out  out  serial data (clk ? hi_q : lo_q)
//   frame    out  high for every cycle whose two half-cycles carry word data
//   busy     out  a word is loaded or being shifted
// Build option:
//   DDR_TX_PARITY_EN - append one trailing pair per word: high phase carries
//                      even parity of the word, low phase carries IDLE_LEVEL
// ============================================================================
module ddr_serializer_tx #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             frame,
  output logic             busy
);

  localparam int PAIRS = WIDTH / 2;
`ifdef DDR_TX_PARITY_EN
  localparam int LOAD_PAIRS = PAIRS + 1;
`else
  localparam int LOAD_PAIRS = PAIRS;
`endif
  localparam int               CNT_W    = $clog2(LOAD_PAIRS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_PAIRS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             hi_q;
  logic             lo_stage;
  logic             lo_q;
  logic             accept;
  logic             pop_hi;
  logic             pop_lo;

  // Ready while at most one pair remains, so the next word loads on the same
  // edge the final pair is popped and the frame stays continuous.
  assign in_ready = rstb && (cnt <= CNT_ONE);
  assign accept   = in_valid && in_ready;
  assign busy     = (cnt != '0) || frame;

  // Both phase registers reset to IDLE_LEVEL, so ser_out idles in either
  // clk phase as soon as rstb falls.
  assign ser_out  = clk ? hi_q : lo_q;

`ifdef DDR_TX_PARITY_EN
  logic parity_q;

  // Parity is captured with the word; the last count step emits it in place
  // of data (sr has already been fully shifted out by then).
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^in_data;
    end
  end

  always_comb begin
    pop_hi = sr[WIDTH-1];
    pop_lo = sr[WIDTH-2];
    if (cnt == CNT_ONE) begin
      pop_hi = parity_q;
      pop_lo = IDLE_LEVEL;
    end
  end
`else
  assign pop_hi = sr[WIDTH-1];
  assign pop_lo = sr[WIDTH-2];
`endif

  // Posedge domain: pop the next pair, then let a load override sr/cnt.
  // The popped pair still goes out even when a new word loads on this edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sr       <= '0;
      cnt      <= '0;
      hi_q     <= IDLE_LEVEL;
      lo_stage <= IDLE_LEVEL;
      frame    <= 1'b0;
    end else begin
      if (cnt != '0) begin
        hi_q     <= pop_hi;
        lo_stage <= pop_lo;
        sr       <= sr << 2;
        cnt      <= cnt - CNT_ONE;
        frame    <= 1'b1;
      end else begin
        hi_q     <= IDLE_LEVEL;
        lo_stage <= IDLE_LEVEL;
        frame    <= 1'b0;
      end
      if (accept) begin
        sr  <= in_data;
        cnt <= CNT_LOAD;
      end
    end
  end

  // Negedge domain: half-cycle transfer of the low-phase bit.
  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      lo_q <= IDLE_LEVEL;
    end else begin
      lo_q <= lo_stage;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_serializer_tx
// Description : Self-checking bench for ddr_serializer_tx. Accepted words are
//               expanded into expected bit-pairs on a scoreboard queue; one
//               pair is retired per clk cycle and compared in both phases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_serializer_tx;

  localparam int   WIDTH = 8;
  localparam logic IDLE  = 1'b0;

  logic             clk = 1'b0;
  logic             rstb;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             frame;
  logic             busy;

  int tests = 0;
  int fails = 0;

  logic [1:0] sb[$];   // expected {high bit, low bit} per frame cycle
  logic       cur_hi;
  logic       cur_lo;
  logic       cur_fr;

  ddr_serializer_tx #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .frame    (frame),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @%0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int k = 0; k < WIDTH / 2; k++) begin
      sb.push_back({d[WIDTH-1-2*k], d[WIDTH-2-2*k]});
    end
`ifdef DDR_TX_PARITY_EN
    sb.push_back({^d, IDLE});
`endif
  endtask

  // Entered 5 time units before a posedge; leaves at the same point of the
  // next cycle.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, output bit acc);
    logic       exp_rdy;
    logic [1:0] p;
    in_valid = v;
    in_data  = d;
    exp_rdy  = (sb.size() <= 1);
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (sb.size() > 0) begin
      p      = sb.pop_front();
      cur_hi = p[1];
      cur_lo = p[0];
      cur_fr = 1'b1;
    end else begin
      cur_hi = IDLE;
      cur_lo = IDLE;
      cur_fr = 1'b0;
    end
    acc = v && exp_rdy;
    if (acc) push_word(d);
    #5;
    chk("ser_out_hi", ser_out, cur_hi);
    chk("frame", frame, cur_fr);
    chk("busy", busy, (sb.size() != 0) || cur_fr);
    @(negedge clk);
    #5;
    chk("ser_out_lo", ser_out, cur_lo);
  endtask

  task automatic idle_steps(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, a);
  endtask

  // Send one word, holding in_valid until the model says it was taken.
  task automatic send(input logic [WIDTH-1:0] d);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, d, a);
    if (!a) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  // Reset asserted in the high phase of the next cycle.
  task automatic reset_pulse();
    logic [1:0] p;
    in_valid = 1'b0;
    chk("in_ready_pre_rst", in_ready, sb.size() <= 1);
    @(posedge clk);
    if (sb.size() > 0) begin
      p = sb.pop_front();
      cur_hi = p[1];
    end else begin
      cur_hi = IDLE;
    end
    #3;
    chk("ser_out_pre_rst", ser_out, cur_hi);
    rstb = 1'b0;
    #1;
    chk("rst_ser_out", ser_out, IDLE);
    chk("rst_frame", frame, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    sb.delete();
    cur_hi = IDLE;
    cur_lo = IDLE;
    cur_fr = 1'b0;
    @(negedge clk);
    #5;
    chk("rst_ser_out_lo", ser_out, IDLE);
    chk("rst_in_ready_lo", in_ready, 1'b0);
    @(posedge clk);
    #5;
    chk("rst_frame_hold", frame, 1'b0);
    chk("rst_ser_out_hold", ser_out, IDLE);
    @(negedge clk);
    #2;
    rstb = 1'b1;
    #3;
  endtask

  initial begin
    bit a;
    rstb     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cur_hi   = IDLE;
    cur_lo   = IDLE;
    cur_fr   = 1'b0;
    #2;
    chk("init_ser_out", ser_out, IDLE);
    chk("init_frame", frame, 1'b0);
    chk("init_in_ready", in_ready, 1'b0);
    chk("init_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rstb = 1'b1;
    #3;

    // Single word
    send(8'hA5);
    idle_steps(6);

    // Back-to-back: FF then 00 with in_valid held high
    send(8'hFF);
    send(8'h00);
    idle_steps(6);

    // Stall between words
    send(8'h3C);
    idle_steps(7);
    send(8'hC3);
    idle_steps(6);

    // Reset during the second pair of a word
    send(8'h96);
    idle_steps(1);
    reset_pulse();
    send(8'h81);
    idle_steps(6);

    // Parity-distinguishing words, then random traffic
    send(8'h07);
    idle_steps(6);
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), a);
    end
    idle_steps(7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
